// File: rtl/input_feed_controller.sv
// input_feed_controller: sequences one operand stream into the 8x8 skew parser, then drains it with zero beats
module input_feed_controller #(
  parameter int DATA_WIDTH = 16,
  parameter int ROWS       = 8,
  parameter int CNT_W      = 16,
  parameter int DRAIN_FULL = 10,
  parameter int DRAIN_TILE = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [CNT_W-1:0]           k_len,
  input  logic                       tile_req,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [ROWS*DATA_WIDTH-1:0] s_data_0,
  input  logic [ROWS*DATA_WIDTH-1:0] s_data_1,
  input  logic                       pe_stall,
  output logic                       par_enable,
  output logic                       par_tile,
  output logic [ROWS*DATA_WIDTH-1:0] par_in_0,
  output logic [ROWS*DATA_WIDTH-1:0] par_in_1,
  output logic                       busy,
  output logic                       done
);
  localparam int DCW = $clog2(DRAIN_FULL + 1);
  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [DCW-1:0]   drain_cnt_q, drain_cnt_d;
  logic             par_tile_q, par_tile_d;
  logic             feed_go, drain_go;
  assign feed_go    = (state_q == FEED) && s_valid && !pe_stall;
  assign drain_go   = (state_q == DRAIN) && !pe_stall;
  assign s_ready    = (state_q == FEED) && !pe_stall;
  assign par_enable = feed_go || drain_go;
  assign par_tile   = par_tile_q;
  assign par_in_0   = (state_q == FEED) ? s_data_0 : '0;
  assign par_in_1   = (state_q == FEED && par_tile_q) ? s_data_1 : '0;
  assign busy       = (state_q == FEED) || (state_q == DRAIN);
  assign done       = (state_q == DONE);
  // next state: counters only move on cycles that actually enable the parser
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    drain_cnt_d = drain_cnt_q;
    par_tile_d  = par_tile_q;
    case (state_q)
      IDLE: if (start) begin
        state_d    = (k_len == '0) ? DONE : FEED;
        beat_cnt_d = k_len;
        par_tile_d = (k_len == '0) ? par_tile_q : tile_req;
      end
      FEED: if (feed_go) begin
        beat_cnt_d = beat_cnt_q - CNT_W'(1);
        if (beat_cnt_q == CNT_W'(1)) begin
          state_d     = DRAIN;
          drain_cnt_d = par_tile_q ? DCW'(DRAIN_TILE) : DCW'(DRAIN_FULL);
        end
      end
      DRAIN: if (drain_go) begin
        drain_cnt_d = drain_cnt_q - DCW'(1);
        state_d     = (drain_cnt_q == DCW'(1)) ? DONE : DRAIN;
      end
      default: begin
        state_d    = IDLE;
        par_tile_d = 1'b0;
      end
    endcase
  end
  // state, counters and tile select registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      drain_cnt_q <= '0;
      par_tile_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      par_tile_q  <= par_tile_d;
    end
  end
endmodule

// File: tb/tb_input_feed_controller.sv
// tb_input_feed_controller: table-driven jobs with a per-cycle reference model and a data scoreboard
module tb_input_feed_controller;
  localparam int VW = 128;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [15:0]   k_len = '0;
  logic          tile_req = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [VW-1:0] s_data_0 = '0;
  logic [VW-1:0] s_data_1 = '0;
  logic          pe_stall = 1'b0;
  logic          par_enable, par_tile, busy, done;
  logic [VW-1:0] par_in_0, par_in_1;

  input_feed_controller dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .tile_req(tile_req),
    .s_valid(s_valid), .s_ready(s_ready), .s_data_0(s_data_0), .s_data_1(s_data_1),
    .pe_stall(pe_stall), .par_enable(par_enable), .par_tile(par_tile),
    .par_in_0(par_in_0), .par_in_1(par_in_1), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] k;
    logic        t;
    logic [15:0] vm;
    logic [15:0] sm;
    int          en;
    int          lat;
    int          bs_at;
    int          rs_at;
  } vec_t;
  typedef struct {
    logic [VW-1:0] a;
    logic [VW-1:0] b;
  } beat_t;

  vec_t  tab[11];
  beat_t sb[$];
  int    checks = 0, errors = 0;
  int    m_st = 0, m_beat = 0, m_drain = 0, bi = 0;
  logic  m_tile = 1'b0;
  int    en_cnt, lat, jc;

  function automatic logic [VW-1:0] d0f(int i);
    return {2{32'h1000_0000 + i, 32'hA5A5_0000 ^ i}};
  endfunction
  function automatic logic [VW-1:0] d1f(int i);
    return {2{32'h2000_0000 + i, 32'h5A5A_0000 ^ i}};
  endfunction

  task automatic chk(input string n, input logic [VW-1:0] a, input logic [VW-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask

  task automatic step();
    beat_t b;
    @(negedge clk);
    chk("s_ready", VW'(s_ready), VW'(m_st == 1 && !pe_stall));
    chk("par_enable", VW'(par_enable), VW'((m_st == 1 && s_valid && !pe_stall) || (m_st == 2 && !pe_stall)));
    chk("busy", VW'(busy), VW'(m_st == 1 || m_st == 2));
    chk("done", VW'(done), VW'(m_st == 3));
    chk("par_tile", VW'(par_tile), VW'(m_tile));
    if (par_enable) begin
      en_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty got enable want none");
      end else begin
        b = sb.pop_front();
        chk("par_in_0", par_in_0, b.a);
        chk("par_in_1", par_in_1, b.b);
      end
    end
    if (done && lat == 0) lat = jc;
    @(posedge clk);
    if (rst) begin
      m_st = 0; m_beat = 0; m_drain = 0; m_tile = 1'b0;
    end else if (m_st == 0) begin
      if (start) begin
        m_st = (k_len == 0) ? 3 : 1;
        m_beat = int'(k_len);
        if (k_len != 0) m_tile = tile_req;
      end
    end else if (m_st == 1) begin
      if (s_valid && !pe_stall) begin
        bi++;
        if (m_beat == 1) begin
          m_st = 2;
          m_drain = m_tile ? 3 : 10;
        end
        m_beat--;
      end
    end else if (m_st == 2) begin
      if (!pe_stall) begin
        if (m_drain == 1) m_st = 3;
        m_drain--;
      end
    end else begin
      m_st = 0;
      m_tile = 1'b0;
    end
    #1;
  endtask

  task automatic run(input vec_t v);
    int lim;
    en_cnt = 0; lat = 0; bi = 0;
    start = 1'b1; k_len = v.k; tile_req = v.t; s_valid = 1'b0; pe_stall = 1'b0;
    s_data_0 = d0f(0); s_data_1 = d1f(0);
    for (int i = 0; i < int'(v.k); i++) sb.push_back('{d0f(i), v.t ? d1f(i) : '0});
    if (v.k != 0) for (int i = 0; i < (v.t ? 3 : 10); i++) sb.push_back('{'0, '0});
    jc = 0;
    step();
    start = 1'b0;
    lim = (v.lat > 0 ? v.lat : 12) + 3;
    for (int j = 1; j <= lim && lat == 0; j++) begin
      jc = j;
      s_valid = (j <= 16) ? v.vm[j-1] : 1'b1;
      pe_stall = (j <= 16) ? v.sm[j-1] : 1'b0;
      start = (j == v.bs_at);
      if (j == v.bs_at) begin
        k_len = 16'd7;
        tile_req = 1'b1;
      end
      rst = (j == v.rs_at);
      s_data_0 = d0f(bi);
      s_data_1 = d1f(bi);
      step();
    end
    rst = 1'b0; start = 1'b0; s_valid = 1'b0; pe_stall = 1'b0;
    if (v.rs_at != 0) sb.delete();
    chk("enable_count", VW'(en_cnt), VW'(v.en));
    chk("done_cycle", VW'(lat), VW'(v.lat));
    step();
  endtask

  initial begin
    #5ms;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

  initial begin
    tab[0]  = '{16'd4,     1'b0, 16'hFFFF, 16'h0000, 14,    15,    0, 0};
    tab[1]  = '{16'd4,     1'b1, 16'hFFFF, 16'h0000, 7,     8,     0, 0};
    tab[2]  = '{16'd3,     1'b0, 16'h5555, 16'h0000, 13,    16,    0, 0};
    tab[3]  = '{16'd4,     1'b0, 16'hFFFF, 16'h0186, 14,    19,    0, 0};
    tab[4]  = '{16'd1,     1'b1, 16'hFFFF, 16'h0000, 4,     5,     0, 0};
    tab[5]  = '{16'd0,     1'b0, 16'hFFFF, 16'h0000, 0,     1,     0, 0};
    tab[6]  = '{16'd2,     1'b1, 16'hFFFE, 16'h0008, 5,     8,     0, 0};
    tab[7]  = '{16'd3,     1'b0, 16'hFFFF, 16'h0000, 13,    14,    2, 0};
    tab[8]  = '{16'd2,     1'b0, 16'hFFFF, 16'h0000, 5,     0,     0, 5};
    tab[9]  = '{16'd5,     1'b1, 16'hFFFF, 16'h0000, 8,     9,     0, 0};
    tab[10] = '{16'hFFFF,  1'b1, 16'hFFFF, 16'h0000, 65538, 65539, 0, 0};
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", VW'(busy), '0);
    chk("rst_done", VW'(done), '0);
    chk("rst_par_tile", VW'(par_tile), '0);
    chk("rst_par_enable", VW'(par_enable), '0);
    chk("rst_s_ready", VW'(s_ready), '0);
    step();
    rst = 1'b0;
    step();
    for (int r = 0; r < 11; r++) run(tab[r]);
    chk("sb_left", VW'(sb.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
